// File: rtl/cpu_sched_pkg.sv
// Shared types for the CPU memory scheduler: one-hot FSM states and owner tags.
package cpu_sched_pkg;

  // Bit positions of each state inside the one-hot encoding
  localparam logic [1:0] IDX_IDLE  = 2'd0;
  localparam logic [1:0] IDX_ISSUE = 2'd1;
  localparam logic [1:0] IDX_WAIT  = 2'd2;
  localparam logic [1:0] IDX_RESP  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_RESP  = 4'b1000
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_IF) ? OWN_MEM : OWN_IF;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: masked requests, tie broken by the priority pointer.
module rr_arb2
  import cpu_sched_pkg::*;
(
  input  logic   i_req_if,
  input  logic   i_req_mem,
  input  logic   i_mask_if,
  input  logic   i_mask_mem,
  input  owner_t i_prio,
  output logic   o_grant,
  output owner_t o_owner
);

  logic w_elig_if;
  logic w_elig_mem;

  // Pick the single eligible requester, or the prioritised one on a tie
  always_comb begin
    w_elig_if  = i_req_if & ~i_mask_if;
    w_elig_mem = i_req_mem & ~i_mask_mem;
    o_grant    = w_elig_if | w_elig_mem;
    o_owner    = OWN_IF;
    if (w_elig_if && w_elig_mem) begin
      o_owner = i_prio;
    end else if (w_elig_mem) begin
      o_owner = OWN_MEM;
    end
  end

endmodule

// File: rtl/cpu_mem_sched.sv
// Shares one wrapper master channel between instruction fetch and data access.
module cpu_mem_sched
  import cpu_sched_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_done,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_write,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_done,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                cpu_stall,
  output logic                timeout_err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  // Counter only has to reach TIMEOUT-1
  localparam int unsigned CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t              r_state;
  state_t              w_state_nxt;
  owner_t              r_owner;
  owner_t              r_prio;      // requester that wins the next tie
  logic                r_mask_if;
  logic                r_mask_mem;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_m_valid;
  logic                r_m_write;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic [STRB_W-1:0]   r_m_wstrb;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_mem_rdata;
  logic                r_timeout;

  logic                w_grant;
  owner_t              w_gnt_owner;
  logic                w_do_grant;
  logic                w_capture;
  logic                w_wd_fire;
  logic                w_wd_limit;
  logic                w_if_done;
  logic                w_mem_done;

  rr_arb2 u_arb (
    .i_req_if   (if_req),
    .i_req_mem  (mem_req),
    .i_mask_if  (r_mask_if),
    .i_mask_mem (r_mask_mem),
    .i_prio     (r_prio),
    .o_grant    (w_grant),
    .o_owner    (w_gnt_owner)
  );

  assign w_wd_limit = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  // Next-state and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_do_grant  = 1'b0;
    w_capture   = 1'b0;
    w_wd_fire   = 1'b0;
    unique case (1'b1)
      r_state[IDX_IDLE]: begin
        if (w_grant) begin
          w_state_nxt = ST_ISSUE;
          w_do_grant  = 1'b1;
        end
      end
      r_state[IDX_ISSUE]: begin
        // A completion arriving with the accept skips WAIT entirely
        if (m_ready) begin
          w_state_nxt = m_done ? ST_RESP : ST_WAIT;
          w_capture   = m_done;
        end
      end
      r_state[IDX_WAIT]: begin
        if (m_done) begin
          w_state_nxt = ST_RESP;
          w_capture   = 1'b1;
        end else if (w_wd_limit) begin
          w_state_nxt = ST_RESP;
          w_wd_fire   = 1'b1;
        end
      end
      r_state[IDX_RESP]: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload, response data, arbitration history and watchdog
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_owner     <= OWN_IF;
      r_prio      <= OWN_IF;
      r_mask_if   <= 1'b0;
      r_mask_mem  <= 1'b0;
      r_cnt       <= '0;
      r_m_valid   <= 1'b0;
      r_m_write   <= 1'b0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_m_wstrb   <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_timeout   <= 1'b0;
    end else begin
      // Mask lasts only for the cycle right after a done
      r_mask_if  <= 1'b0;
      r_mask_mem <= 1'b0;
      if (w_do_grant) begin
        r_owner   <= w_gnt_owner;
        r_m_valid <= 1'b1;
        if (w_gnt_owner == OWN_IF) begin
          r_m_write <= 1'b0;
          r_m_addr  <= if_addr;
          r_m_wdata <= '0;
          r_m_wstrb <= '0;
        end else begin
          r_m_write <= mem_we;
          r_m_addr  <= mem_addr;
          r_m_wdata <= mem_wdata;
          r_m_wstrb <= mem_wstrb;
        end
      end
      if (r_state[IDX_ISSUE] && m_ready) begin
        r_m_valid <= 1'b0;
        r_cnt     <= '0;
      end else if (r_state[IDX_WAIT]) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_capture) begin
        if (r_owner == OWN_IF) r_if_rdata <= m_rdata;
        else                   r_mem_rdata <= m_rdata;
      end
      if (w_wd_fire) begin
        r_timeout <= 1'b1;
        if (r_owner == OWN_IF) r_if_rdata <= '0;
        else                   r_mem_rdata <= '0;
      end
      if (r_state[IDX_RESP]) begin
        r_prio <= other_owner(r_owner);
        if (r_owner == OWN_IF) r_mask_if <= 1'b1;
        else                   r_mask_mem <= 1'b1;
      end
    end
  end

  assign w_if_done   = r_state[IDX_RESP] & (r_owner == OWN_IF);
  assign w_mem_done  = r_state[IDX_RESP] & (r_owner == OWN_MEM);
  assign if_done     = w_if_done;
  assign mem_done    = w_mem_done;
  assign if_rdata    = r_if_rdata;
  assign mem_rdata   = r_mem_rdata;
  assign m_valid     = r_m_valid;
  assign m_write     = r_m_write;
  assign m_addr      = r_m_addr;
  assign m_wdata     = r_m_wdata;
  assign m_wstrb     = r_m_wstrb;
  assign timeout_err = r_timeout;
  assign cpu_stall   = (if_req & ~w_if_done) | (mem_req & ~w_mem_done);

endmodule

// File: tb/tb_cpu_mem_sched.sv
// Self-checking bench for cpu_mem_sched: directed scenarios plus randomized rounds.
module tb_cpu_mem_sched;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned TMO = 8;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          m_valid;
  logic          m_ready;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          m_done;
  logic [DW-1:0] m_rdata;
  logic          cpu_stall;
  logic          timeout_err;

  cpu_mem_sched #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_done     (if_done),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .mem_done    (mem_done),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_write     (m_write),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_done      (m_done),
    .m_rdata     (m_rdata),
    .cpu_stall   (cpu_stall),
    .timeout_err (timeout_err)
  );

  always #5 ACLK = ~ACLK;

  int unsigned cycle = 0;
  always @(posedge ACLK) cycle <= cycle + 1;

  int errors = 0;
  int checks = 0;

  // Reference model state: who was served last, and what each requester should read back
  bit            last_mem;
  logic [DW-1:0] exp_if_rdata;
  logic [DW-1:0] exp_mem_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic at_mid();
    @(negedge ACLK);
  endtask

  task automatic check_stall(input string tag, input bit dif, input bit dmem);
    chk($sformatf("%s.stall", tag), cpu_stall, (if_req & ~dif) | (mem_req & ~dmem));
  endtask

  task automatic check_zero(input string tag);
    chk($sformatf("%s.m_valid", tag), m_valid, 0);
    chk($sformatf("%s.m_write", tag), m_write, 0);
    chk($sformatf("%s.m_addr", tag), m_addr, 0);
    chk($sformatf("%s.m_wdata", tag), m_wdata, 0);
    chk($sformatf("%s.m_wstrb", tag), m_wstrb, 0);
    chk($sformatf("%s.if_rdata", tag), if_rdata, 0);
    chk($sformatf("%s.mem_rdata", tag), mem_rdata, 0);
    chk($sformatf("%s.dones", tag), {if_done, mem_done}, 0);
    chk($sformatf("%s.timeout_err", tag), timeout_err, 0);
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    mem_req   = 1'b0;
    m_ready   = 1'b0;
    m_done    = 1'b0;
    m_rdata   = '0;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    idle_inputs();
    next_cyc();
    next_cyc();
    ARESETn = 1'b1;
    last_mem      = 1'b1;  // IF wins the first tie after reset
    exp_if_rdata  = '0;
    exp_mem_rdata = '0;
  endtask

  // Called in the cycle the grant is expected. Wrapper withholds m_ready for rw cycles,
  // then returns rd after dw further cycles (or together with m_ready when same=1).
  task automatic serve(input bit own_mem, input int rw, input int dw, input bit same,
                       input logic [DW-1:0] rd, input string tag);
    int unsigned   g;
    logic [AW-1:0] ea;
    bit            ewr;
    logic [SW-1:0] es;
    logic [DW-1:0] ewd;
    g = cycle;
    if (own_mem) begin
      ea = mem_addr; ewr = mem_we; es = mem_wstrb; ewd = mem_wdata;
    end else begin
      ea = if_addr; ewr = 1'b0; es = '0; ewd = '0;
    end
    at_mid();
    chk($sformatf("%s.grant_valid", tag), m_valid, 0);
    check_stall(tag, 0, 0);
    next_cyc();
    for (int k = 0; k <= rw; k++) begin
      m_ready = (k == rw);
      if (k == rw && same) begin
        m_done  = 1'b1;
        m_rdata = rd;
      end
      at_mid();
      chk($sformatf("%s.issue_valid", tag), m_valid, 1);
      chk($sformatf("%s.m_addr", tag), m_addr, ea);
      chk($sformatf("%s.m_write", tag), m_write, ewr);
      chk($sformatf("%s.m_wstrb", tag), m_wstrb, es);
      if (own_mem) chk($sformatf("%s.m_wdata", tag), m_wdata, ewd);
      chk($sformatf("%s.early_done", tag), {if_done, mem_done}, 0);
      check_stall(tag, 0, 0);
      next_cyc();
    end
    m_ready = 1'b0;
    m_done  = 1'b0;
    m_rdata = $urandom;
    if (!same) begin
      for (int k = 0; k <= dw; k++) begin
        if (k == dw) begin
          m_done  = 1'b1;
          m_rdata = rd;
        end
        at_mid();
        chk($sformatf("%s.wait_valid", tag), m_valid, 0);
        chk($sformatf("%s.wait_done", tag), {if_done, mem_done}, 0);
        check_stall(tag, 0, 0);
        next_cyc();
      end
      m_done  = 1'b0;
      m_rdata = $urandom;
    end
    if (own_mem) exp_mem_rdata = rd;
    else         exp_if_rdata  = rd;
    at_mid();
    chk($sformatf("%s.if_done", tag), if_done, !own_mem);
    chk($sformatf("%s.mem_done", tag), mem_done, own_mem);
    chk($sformatf("%s.if_rdata", tag), if_rdata, exp_if_rdata);
    chk($sformatf("%s.mem_rdata", tag), mem_rdata, exp_mem_rdata);
    chk($sformatf("%s.latency", tag), cycle - g, same ? 2 + rw : 3 + rw + dw);
    check_stall(tag, !own_mem, own_mem);
    last_mem = own_mem;
    next_cyc();
    chk($sformatf("%s.done_pulse", tag), {if_done, mem_done}, 0);
  endtask

  initial begin
    int unsigned g;
    int          s;
    bit          first;
    if_addr   = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;

    // Reset values
    do_reset();
    at_mid();
    check_zero("reset");
    chk("reset.stall", cpu_stall, 0);
    next_cyc();

    // IF alone
    if_addr = 32'h100;
    if_req  = 1'b1;
    serve(1'b0, 1, 3, 1'b0, 32'hDEAD_BEEF, "t1_if");
    if_req = 1'b0;
    next_cyc();

    // Simultaneous requests from reset: IF, MEM, IF while both stay high
    do_reset();
    next_cyc();
    if_addr   = 32'h200;
    mem_addr  = 32'h0000_4000;
    mem_we    = 1'b1;
    mem_wdata = 32'hA5A5_A5A5;
    mem_wstrb = 4'hF;
    if_req    = 1'b1;
    mem_req   = 1'b1;
    serve(1'b0, 0, 1, 1'b0, 32'h1111_0001, "t2_if_a");
    serve(1'b1, 1, 0, 1'b0, 32'h2222_0002, "t2_mem");
    serve(1'b0, 0, 0, 1'b0, 32'h3333_0003, "t2_if_b");
    if_req  = 1'b0;
    mem_req = 1'b0;
    next_cyc();

    // IF held across its own done: the mask must delay the regrant by one cycle
    if_addr = 32'h240;
    if_req  = 1'b1;
    serve(1'b0, 0, 0, 1'b0, 32'h4444_0004, "mask_a");
    if_addr = 32'h244;
    next_cyc();
    serve(1'b0, 0, 0, 1'b0, 32'h4444_0005, "mask_b");
    if_req = 1'b0;
    next_cyc();

    // MEM read with m_ready and m_done together
    mem_we   = 1'b0;
    mem_addr = 32'h0000_8010;
    mem_req  = 1'b1;
    serve(1'b1, 0, 0, 1'b1, 32'hCAFE_F00D, "t3_same");
    mem_req = 1'b0;
    next_cyc();

    // m_ready withheld for 10 cycles
    if_addr = 32'h600;
    if_req  = 1'b1;
    serve(1'b0, 10, 2, 1'b0, 32'h6666_0006, "t6_hold");
    if_req = 1'b0;
    next_cyc();

    // Randomized rounds
    for (int r = 0; r < 24; r++) begin
      s         = int'($urandom_range(1, 3));
      if_addr   = $urandom;
      mem_addr  = $urandom;
      mem_we    = 1'($urandom_range(0, 1));
      mem_wdata = $urandom;
      mem_wstrb = SW'($urandom);
      if_req    = s[0];
      mem_req   = s[1];
      first     = (s == 3) ? !last_mem : (s == 2);
      serve(first, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, $urandom, $sformatf("rnd%0d_a", r));
      if (first) mem_req = 1'b0;
      else       if_req  = 1'b0;
      if (s == 3) begin
        serve(!first, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0, $urandom, $sformatf("rnd%0d_b", r));
        if_req  = 1'b0;
        mem_req = 1'b0;
      end
      // Stray handshakes while idle must be ignored
      m_ready = 1'($urandom_range(0, 1));
      m_done  = 1'($urandom_range(0, 1));
      m_rdata = $urandom;
      at_mid();
      chk($sformatf("rnd%0d.idle_valid", r), m_valid, 0);
      next_cyc();
      m_ready = 1'b0;
      m_done  = 1'b0;
      at_mid();
      chk($sformatf("rnd%0d.stray_done", r), {if_done, mem_done}, 0);
      chk($sformatf("rnd%0d.stray_valid", r), m_valid, 0);
      chk($sformatf("rnd%0d.if_keep", r), if_rdata, exp_if_rdata);
      chk($sformatf("rnd%0d.mem_keep", r), mem_rdata, exp_mem_rdata);
      next_cyc();
    end

    // Watchdog: accepted but never completed
    chk("t4.pre_timeout", timeout_err, 0);
    if_addr = 32'h700;
    if_req  = 1'b1;
    g = cycle;
    next_cyc();
    m_ready = 1'b1;
    at_mid();
    chk("t4.issue_valid", m_valid, 1);
    next_cyc();
    m_ready = 1'b0;
    for (int k = 0; k < int'(TMO); k++) begin
      at_mid();
      chk($sformatf("t4.wait%0d_err", k), timeout_err, 0);
      chk($sformatf("t4.wait%0d_done", k), {if_done, mem_done}, 0);
      next_cyc();
    end
    exp_if_rdata = '0;
    at_mid();
    chk("t4.if_done", if_done, 1);
    chk("t4.mem_done", mem_done, 0);
    chk("t4.timeout_err", timeout_err, 1);
    chk("t4.if_rdata", if_rdata, 0);
    chk("t4.mem_keep", mem_rdata, exp_mem_rdata);
    chk("t4.latency", cycle - g, 2 + TMO);
    last_mem = 1'b0;
    next_cyc();
    if_req  = 1'b0;
    m_done  = 1'b1;
    m_rdata = 32'hBAD0_BAD0;
    next_cyc();
    m_done = 1'b0;
    at_mid();
    chk("t4.late_done", {if_done, mem_done}, 0);
    chk("t4.late_rdata", if_rdata, 0);
    chk("t4.sticky", timeout_err, 1);
    chk("t4.late_valid", m_valid, 0);
    next_cyc();

    // Reset during WAIT abandons the transaction
    if_addr = 32'h800;
    if_req  = 1'b1;
    next_cyc();
    m_ready = 1'b1;
    next_cyc();
    m_ready = 1'b0;
    next_cyc();
    #2;
    ARESETn = 1'b0;
    if_req  = 1'b0;
    #1;
    check_zero("t5.async");
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      at_mid();
      chk($sformatf("t5.hold%0d_done", k), {if_done, mem_done}, 0);
      chk($sformatf("t5.hold%0d_valid", k), m_valid, 0);
    end
    next_cyc();
    ARESETn       = 1'b1;
    last_mem      = 1'b1;
    exp_if_rdata  = '0;
    exp_mem_rdata = '0;
    next_cyc();
    at_mid();
    chk("t5.no_done", {if_done, mem_done}, 0);
    next_cyc();
    if_addr = 32'h900;
    if_req  = 1'b1;
    serve(1'b0, 0, 1, 1'b0, 32'h9999_0009, "t5_after");
    if_req = 1'b0;
    next_cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so a stuck run still terminates
  initial begin
    #200000;
    $display("FAIL time_limit: observed=running expected=finished");
    $fatal(1);
  end

endmodule
